// File: rtl/id_table_pkg.sv
// Shared definitions for the player-ID table: sentinel/guest IDs, failure codes and FSM encodings.
// The enrollment writer and the login checker both import this package.
package id_table_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int RD_LAT_DEF = 2;

  localparam logic [15:0] SENTINEL_ID = 16'hFFFF;
  localparam logic [15:0] GUEST_ID    = 16'h8888;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_RESERVED = 2'd1,
    FC_DUP      = 2'd2,
    FC_FULL     = 2'd3
  } fail_code_t;

  typedef enum logic [1:0] {
    DIGIT1,
    DIGIT2,
    DIGIT3,
    DIGIT4
  } digit_state_t;

  // ST_IDLE is the enrollment side's view of DIGIT1..DIGIT4 (collector active).
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_VALIDATE,
    ST_FETCH,
    ST_WAIT1,
    ST_WAIT2,
    ST_CATCH,
    ST_COMPARE,
    ST_WRITE_ID,
    ST_WRITE_SENT,
    ST_DONE,
    ST_FAIL
  } enroll_state_t;

  // IDs that can never be stored: the end-of-table marker and the guest login.
  function automatic logic is_reserved_id(input logic [15:0] id);
    return (id == SENTINEL_ID) || (id == GUEST_ID);
  endfunction

endpackage

// File: rtl/id_enroll_if.sv
// ID RAM port bundle: the enrollment writer is the master, the table RAM the slave.
interface id_enroll_if
  import id_table_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] ID_RAMaddr;
  logic [15:0]       ID_RAMwdata;
  logic              ID_RAMwe;
  logic [15:0]       ID_RAMrdata;

  modport master (
    output ID_RAMaddr,
    output ID_RAMwdata,
    output ID_RAMwe,
    input  ID_RAMrdata
  );

  modport slave (
    input  ID_RAMaddr,
    input  ID_RAMwdata,
    input  ID_RAMwe,
    output ID_RAMrdata
  );

endinterface

// File: rtl/id_enroll_digit_collect.sv
// Four-nibble keypad capture with cancel; emits the assembled 16-bit ID and a one-cycle id_valid.
// Inputs are ignored while hold is high or while id_valid is being presented.
module id_digit_collect
  import id_table_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        cancel,
  input  logic        hold,
  output logic [15:0] id,
  output logic        id_valid
);

  digit_state_t state, state_nx;
  logic         accept;
  logic         take;

  assign accept = !hold && !id_valid;
  assign take   = accept && !cancel && enter;

  always_comb begin
    state_nx = state;
    if (accept && cancel) begin
      state_nx = DIGIT1;
    end else if (take) begin
      case (state)
        DIGIT1: state_nx = DIGIT2;
        DIGIT2: state_nx = DIGIT3;
        DIGIT3: state_nx = DIGIT4;
        DIGIT4: state_nx = DIGIT1;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DIGIT1;
      id       <= '0;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      id_valid <= take && (state == DIGIT4);
      if (take) begin
        case (state)
          DIGIT1: id[15:12] <= digit;
          DIGIT2: id[11:8]  <= digit;
          DIGIT3: id[7:4]   <= digit;
          DIGIT4: id[3:0]   <= digit;
        endcase
      end
    end
  end

endmodule

// File: rtl/id_enroll.sv
// Player-ID table writer: validates a keyed-in ID, scans the RAM for duplicates and the
// end-of-table sentinel, stores the ID in the sentinel slot and re-terminates the table.
module id_enroll
  import id_table_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int RD_LAT = RD_LAT_DEF,   // must be >= 2: WAIT1 plus at least one WAIT2
  localparam int IDX_W  = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       PlayerID,
  input  logic             Enroll_enter,
  input  logic             Cancel,
  id_enroll_if.master      ram,
  output logic             Busy,
  output logic             EnrollDone,
  output logic             EnrollFail,
  output logic [1:0]       FailCode,
  output logic [IDX_W-1:0] NewInternalID
);

  enroll_state_t    state, state_nx;
  fail_code_t       fail_code, fail_code_nx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] new_internal_id;
  logic [3:0]       wait_cnt;
  logic [15:0]      rdata_q;
  logic [15:0]      new_id;
  logic             id_valid;
  logic             busy, done, fail, legal;
  logic             last_slot;

  id_digit_collect u_collect (
    .clk      (clk),
    .rst      (rst),
    .digit    (PlayerID),
    .enter    (Enroll_enter),
    .cancel   (Cancel),
    .hold     (busy),
    .id       (new_id),
    .id_valid (id_valid)
  );

  assign last_slot = (idx == IDX_W'(DEPTH - 1));

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_nx     = state;
    fail_code_nx = FC_NONE;
    busy         = 1'b1;
    done         = 1'b0;
    fail         = 1'b0;
    legal        = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (id_valid) state_nx = ST_VALIDATE;
      end
      ST_VALIDATE: begin
        if (is_reserved_id(new_id)) begin
          state_nx     = ST_FAIL;
          fail_code_nx = FC_RESERVED;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: state_nx = ST_WAIT1;
      ST_WAIT1: state_nx = ST_WAIT2;
      ST_WAIT2: if (wait_cnt == 4'(RD_LAT - 2)) state_nx = ST_CATCH;
      ST_CATCH: state_nx = ST_COMPARE;
      ST_COMPARE: begin
        // A last slot without the sentinel means a broken table; treat it as full.
        if (rdata_q == new_id) begin
          state_nx     = ST_FAIL;
          fail_code_nx = FC_DUP;
        end else if (last_slot) begin
          state_nx     = ST_FAIL;
          fail_code_nx = FC_FULL;
        end else if (rdata_q == SENTINEL_ID) begin
          state_nx = ST_WRITE_ID;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      ST_WRITE_ID:   state_nx = ST_WRITE_SENT;
      ST_WRITE_SENT: state_nx = ST_DONE;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_FAIL: begin
        fail     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        legal    = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // An undefined state clears the datapath exactly as reset would.
  always_ff @(posedge clk) begin
    if (!rst || !legal) begin
      ram.ID_RAMaddr  <= '0;
      ram.ID_RAMwdata <= '0;
      ram.ID_RAMwe    <= 1'b0;
      fail_code       <= FC_NONE;
      new_internal_id <= '0;
      idx             <= '0;
      wait_cnt        <= '0;
      rdata_q         <= '0;
    end else begin
      ram.ID_RAMwe <= 1'b0;
      wait_cnt     <= (state == ST_WAIT2) ? wait_cnt + 4'd1 : 4'd0;
      case (state)
        ST_VALIDATE: idx <= '0;
        ST_FETCH:    ram.ID_RAMaddr <= ADDR_W'(idx);
        ST_CATCH:    rdata_q <= ram.ID_RAMrdata;
        ST_COMPARE:  if (state_nx == ST_FETCH) idx <= idx + IDX_W'(1);
        default: ;
      endcase
      // Write strobes are registered on entry so we is high only in the two write states.
      case (state_nx)
        ST_WRITE_ID: begin
          ram.ID_RAMaddr  <= ADDR_W'(idx);
          ram.ID_RAMwdata <= new_id;
          ram.ID_RAMwe    <= 1'b1;
        end
        ST_WRITE_SENT: begin
          ram.ID_RAMaddr  <= ADDR_W'(idx + IDX_W'(1));
          ram.ID_RAMwdata <= SENTINEL_ID;
          ram.ID_RAMwe    <= 1'b1;
        end
        ST_DONE: begin
          new_internal_id <= idx;
          fail_code       <= FC_NONE;
        end
        ST_FAIL: fail_code <= fail_code_nx;
        default: ;
      endcase
    end
  end

  assign Busy          = busy;
  assign EnrollDone    = done;
  assign EnrollFail    = fail;
  assign FailCode      = fail_code;
  assign NewInternalID = new_internal_id;

endmodule
